uart_xfer_ctrl: RTL and testbench
=================================

UART_XFER_CTRL -- requirements
Module: uart_xfer_ctrl

Interface
REQ-001 SHALL have parameter DIVISOR, default 16'd130, the 16550 baud divisor (20 MHz / (16*9600)).
REQ-002 SHALL have parameter LCR_VAL, default 8'h03, the line control value (8N1, DLAB=0).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 5, the maximum number of cycles from stb rise to wb_ack_i.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start_config, input, 1 bit: a rising edge starts or restarts configuration.
REQ-007 SHALL have port config_done, output, 1 bit: high once configuration is complete, until restart, err or reset.
REQ-008 SHALL have ports tx_data (input, 8 bits), tx_valid (input, 1 bit) and tx_ready (output, 1 bit): the byte-to-send handshake.
REQ-009 SHALL have ports rx_data (output, 8 bits), rx_valid (output, 1 bit) and rx_ready (input, 1 bit): the received-byte handshake.
REQ-010 SHALL have port err, output, 1 bit: sticky ack-timeout flag.
REQ-011 SHALL have Wishbone master ports wb_adr_o (3), wb_dat_o (8), wb_dat_i (8), wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o (4) and wb_ack_i, connecting to uart_top.

Function
REQ-012 SHALL use a state machine with states IDLE, CFG, POLL, RX_RD, TX_WR, DONE_WAIT and ERROR.
REQ-013 SHALL, in CFG, issue these writes in order: LCR(3)=0x80|LCR_VAL; DLL(0)=DIVISOR[7:0]; DLM(1)=DIVISOR[15:8]; LCR(3)=LCR_VAL; FCR(2)=0x07; IER(1)=0x00.
REQ-014 SHALL assert config_done in the cycle after the last CFG ack, then enter POLL.
REQ-015 SHALL drive every bus cycle from registers:
- cyc and stb rise together; adr, dat, we and sel are held stable until ack.
- sel is fixed at 4'b0001.
- cyc and stb drop in the cycle after ack.
- At least one idle cycle separates consecutive cycles.
REQ-016 SHALL, in POLL, read LSR(5) and then decide, with RX having priority:
- LSR[0]=1 and rx_valid=0: go to RX_RD.
- Otherwise, LSR[5]=1 and tx_valid=1: go to TX_WR.
- Otherwise: re-poll.
REQ-017 SHALL, in RX_RD, read RBR(0), latch wb_dat_i into rx_data on ack, set rx_valid and return to POLL.
REQ-018 SHALL hold rx_valid and rx_data until the cycle after rx_valid&&rx_ready.
REQ-019 SHALL ignore LSR[0] while rx_valid=1; no byte is overwritten.
REQ-020 SHALL, in TX_WR, write tx_data to THR(0) and pulse tx_ready for exactly one cycle, coincident with the ack cycle.
REQ-021 SHALL require tx_data to remain stable while tx_valid=1 and tx_ready=0.
REQ-022 SHALL count ack-wait cycles from stb rise; if the count reaches ACK_TIMEOUT without ack, drop cyc/stb next cycle, set err, clear config_done and enter ERROR.
REQ-023 SHALL leave ERROR only on a start_config rising edge, which clears err and enters CFG.
REQ-024 SHALL, on a start_config rising edge in POLL or DONE_WAIT, finish any in-flight bus cycle, clear config_done and enter CFG; an edge during CFG is ignored.
REQ-025 SHALL use an ack-timeout counter width of $clog2(ACK_TIMEOUT+1) bits.

Reset
REQ-026 SHALL, on rstn low, asynchronously force: state=IDLE; cyc, stb, we, tx_ready, rx_valid, config_done and err=0; adr=0; dat_o=0; sel=0; rx_data=0; counters=0.
REQ-027 SHALL abandon any in-flight bus cycle on reset mid-cycle; a late ack arriving in IDLE is ignored.
REQ-028 SHALL initialise the start_config edge detector to 0, so that start_config held high across rstn release counts as a rising edge.

Structure
REQ-029 SHALL place UART register addresses (RBR_THR=0, IER_DLM=1, FCR=2, LCR=3, LSR=5), LSR bit indices, the CFG table and the state enum in package uart_ctrl_pkg.
REQ-030 SHALL implement sub-module uart_wb_master (single-transfer Wishbone engine with ack timeout), instantiated once and sequenced by the state machine.

Verification
REQ-031 SHALL verify configuration: rstn release, start_config=1 -> six writes with (adr,dat) = (3,83),(0,82),(1,00),(3,03),(2,07),(1,00), then config_done=1.
REQ-032 SHALL verify TX: tx_valid=1, tx_data=0x5A, LSR returns 0x60 -> one write adr0/0x5A, one tx_ready pulse, and tx_data=0x5A observed on stx_pad_o at 9600 baud.
REQ-033 SHALL verify RX: drive 0xA5 on srx_pad_i with rx_ready=0 -> RBR read, rx_valid=1, rx_data=0xA5, held until rx_ready=1; no further RBR read while rx_valid=1.
REQ-034 SHALL verify priority: LSR=0x61 with tx_valid=1 -> RBR read first, THR write on the following poll.
REQ-035 SHALL verify timeout: slave never acks -> stb drops after 5 cycles, err=1, config_done=0; a new start_config edge -> err=0 and the CFG sequence restarts.
REQ-036 SHALL verify reset mid-operation: rstn low during a THR write -> all outputs at reset values within the same time step, and no tx_ready pulse.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the 16550 UART transfer controller: register map,
// LSR bit positions, controller states and the configuration write table.
package uart_ctrl_pkg;

  localparam logic [2:0] ADR_RBR_THR = 3'd0;
  localparam logic [2:0] ADR_DLL     = 3'd0;
  localparam logic [2:0] ADR_IER_DLM = 3'd1;
  localparam logic [2:0] ADR_FCR     = 3'd2;
  localparam logic [2:0] ADR_LCR     = 3'd3;
  localparam logic [2:0] ADR_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  localparam logic [2:0] CFG_LAST = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    POLL,
    RX_RD,
    TX_WR,
    DONE_WAIT,
    ERROR
  } state_t;

  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] dat;
  } wb_wr_t;

  // Configuration sequence: open the divisor latch, load the divisor,
  // close the latch with the final line format, enable/reset FIFOs, mask IRQs.
  function automatic wb_wr_t cfg_entry(input logic [2:0]  idx,
                                       input logic [15:0] divisor,
                                       input logic [7:0]  lcr);
    wb_wr_t e;
    case (idx)
      3'd0:    begin e.adr = ADR_LCR;     e.dat = 8'h80 | lcr;    end
      3'd1:    begin e.adr = ADR_DLL;     e.dat = divisor[7:0];   end
      3'd2:    begin e.adr = ADR_IER_DLM; e.dat = divisor[15:8];  end
      3'd3:    begin e.adr = ADR_LCR;     e.dat = lcr;            end
      3'd4:    begin e.adr = ADR_FCR;     e.dat = 8'h07;          end
      default: begin e.adr = ADR_IER_DLM; e.dat = 8'h00;          end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/uart_wb_master.sv
// Single-transfer Wishbone master: launches one registered bus cycle per
// request, guarantees an idle cycle between cycles and aborts on ack timeout.
module uart_wb_master #(
  parameter int ACK_TIMEOUT = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic       req_we,
  input  logic [2:0] req_adr,
  input  logic [7:0] req_dat,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

  logic [CW-1:0] wait_cnt;
  logic          gap;

  assign busy    = wb_stb_o;
  assign done    = wb_stb_o && wb_ack_i;
  // wait_cnt holds the number of the current strobe cycle, starting at 1.
  assign timeout = wb_stb_o && !wb_ack_i && (wait_cnt == LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_adr_o <= 3'd0;
      wb_dat_o <= 8'h00;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_sel_o <= 4'b0000;
      wait_cnt <= '0;
      gap      <= 1'b0;
    end else begin
      gap <= 1'b0;
      if (wb_stb_o) begin
        if (done || timeout) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          gap      <= 1'b1;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else if (req && !gap) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= req_we;
        wb_adr_o <= req_adr;
        wb_dat_o <= req_dat;
        wb_sel_o <= 4'b0001;
        wait_cnt <= CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_xfer_ctrl.sv
// Configures a 16550-style UART over Wishbone, then polls LSR to move bytes
// between the UART and the tx/rx valid-ready handshakes.
module uart_xfer_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [15:0] DIVISOR     = 16'd130,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter int          ACK_TIMEOUT = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_config,
  output logic       config_done,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i
);

  state_t     state, state_nx;
  logic [2:0] cfg_idx, cfg_idx_nx;
  logic       config_done_nx, err_nx;
  logic       pend, pend_nx;
  logic       start_q, start_rise;
  logic       req, req_we;
  logic [2:0] req_adr;
  logic [7:0] req_dat;
  logic       xfer_busy, xfer_done, xfer_timeout;
  logic       rx_load;
  wb_wr_t     cfg_wr;

  assign start_rise = start_config && !start_q;
  assign cfg_wr     = cfg_entry(cfg_idx, DIVISOR, LCR_VAL);

  uart_wb_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_master (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .busy     (xfer_busy),
    .done     (xfer_done),
    .timeout  (xfer_timeout),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cfg_idx     <= 3'd0;
      config_done <= 1'b0;
      err         <= 1'b0;
      pend        <= 1'b0;
      start_q     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
    end else begin
      state       <= state_nx;
      cfg_idx     <= cfg_idx_nx;
      config_done <= config_done_nx;
      err         <= err_nx;
      pend        <= pend_nx;
      start_q     <= start_config;
      if (rx_load) begin
        rx_data  <= wb_dat_i;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // A restart request outside CFG is remembered in pend and honoured only
  // once no bus cycle is in flight, so the UART never sees a torn access.
  always_comb begin
    state_nx       = state;
    cfg_idx_nx     = cfg_idx;
    config_done_nx = config_done;
    err_nx         = err;
    pend_nx        = pend;
    req            = 1'b0;
    req_we         = 1'b0;
    req_adr        = ADR_LSR;
    req_dat        = 8'h00;
    tx_ready       = 1'b0;
    rx_load        = 1'b0;

    if (start_rise && (state inside {POLL, DONE_WAIT, RX_RD, TX_WR}))
      pend_nx = 1'b1;

    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nx   = CFG;
          cfg_idx_nx = 3'd0;
        end
      end

      CFG: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = cfg_wr.adr;
        req_dat = cfg_wr.dat;
        if (xfer_timeout) begin
          state_nx       = ERROR;
          err_nx         = 1'b1;
          config_done_nx = 1'b0;
          cfg_idx_nx     = 3'd0;
        end else if (xfer_done) begin
          if (cfg_idx == CFG_LAST) begin
            state_nx       = DONE_WAIT;
            config_done_nx = 1'b1;
            cfg_idx_nx     = 3'd0;
          end else begin
            cfg_idx_nx = cfg_idx + 3'd1;
          end
        end
      end

      DONE_WAIT: begin
        if (pend_nx) begin
          state_nx       = CFG;
          cfg_idx_nx     = 3'd0;
          config_done_nx = 1'b0;
          pend_nx        = 1'b0;
        end else begin
          state_nx = POLL;
        end
      end

      POLL: begin
        if (!xfer_busy) begin
          if (pend_nx) begin
            state_nx       = CFG;
            cfg_idx_nx     = 3'd0;
            config_done_nx = 1'b0;
            pend_nx        = 1'b0;
          end else begin
            req = 1'b1;
          end
        end else if (xfer_timeout) begin
          state_nx       = ERROR;
          err_nx         = 1'b1;
          config_done_nx = 1'b0;
          pend_nx        = 1'b0;
        end else if (xfer_done) begin
          if (pend_nx) begin
            state_nx       = CFG;
            cfg_idx_nx     = 3'd0;
            config_done_nx = 1'b0;
            pend_nx        = 1'b0;
          end else if (wb_dat_i[LSR_DR] && !rx_valid) begin
            state_nx = RX_RD;
          end else if (wb_dat_i[LSR_THRE] && tx_valid) begin
            state_nx = TX_WR;
          end
        end
      end

      RX_RD: begin
        req     = 1'b1;
        req_adr = ADR_RBR_THR;
        if (xfer_timeout) begin
          state_nx       = ERROR;
          err_nx         = 1'b1;
          config_done_nx = 1'b0;
          pend_nx        = 1'b0;
        end else if (xfer_done) begin
          rx_load  = 1'b1;
          state_nx = POLL;
        end
      end

      TX_WR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = ADR_RBR_THR;
        req_dat = tx_data;
        if (xfer_timeout) begin
          state_nx       = ERROR;
          err_nx         = 1'b1;
          config_done_nx = 1'b0;
          pend_nx        = 1'b0;
        end else if (xfer_done) begin
          tx_ready = 1'b1;
          state_nx = POLL;
        end
      end

      ERROR: begin
        if (start_rise) begin
          state_nx   = CFG;
          err_nx     = 1'b0;
          cfg_idx_nx = 3'd0;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_xfer_ctrl.sv
// Self-checking bench for uart_xfer_ctrl: behavioural UART register slave,
// bus-transfer scoreboard, table of poll-decision vectors and corner sequences.
module tb_uart_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start_config = 1'b0;
  logic       config_done;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i = 1'b0;

  int total = 0;
  int bad = 0;
  int tx_pulses = 0;
  int lsr_reads = 0;

  typedef struct {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } xfer_t;
  xfer_t exp_q[$];

  typedef struct {
    string      name;
    logic [7:0] lsr;
    logic       txv;
    logic [7:0] txd;
    logic [7:0] rbr;
    int         kind;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  logic       ack_en = 1'b1;
  int         slave_delay = 0;
  int         wcnt = 0;

  always #5 clk = ~clk;

  uart_xfer_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_config (start_config),
    .config_done  (config_done),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .err          (err),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_we_o      (wb_we_o),
    .wb_stb_o     (wb_stb_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_sel_o     (wb_sel_o),
    .wb_ack_i     (wb_ack_i)
  );

  assign wb_dat_i = (wb_adr_o == 3'd5) ? lsr_val :
                    (wb_adr_o == 3'd0) ? rbr_val : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Slave acks one clock after it sees the strobe, plus slave_delay cycles.
  always @(posedge clk) begin
    #1;
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && ack_en) begin
      if (wcnt >= slave_delay) begin
        wb_ack_i = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wcnt = 0;
    end
  end

  logic  cd_prev = 1'b0;
  logic  ier_prev = 1'b0;
  logic  ier_now;
  xfer_t got_x, exp_x;

  always @(negedge clk) begin
    ier_now = 1'b0;
    if (rstn && config_done && !cd_prev)
      checkOutput("cfg_done_timing", {31'd0, ier_prev}, 32'd1);
    if (rstn && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      got_x.we  = wb_we_o;
      got_x.adr = wb_adr_o;
      got_x.dat = wb_we_o ? wb_dat_o : wb_dat_i;
      checkOutput("sel", {28'd0, wb_sel_o}, 32'd1);
      if (!got_x.we && got_x.adr == 3'd5) begin
        lsr_reads++;
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_xfer: got we=%0d adr=%0d dat=%02h, expected no transfer",
                 got_x.we, got_x.adr, got_x.dat);
      end else begin
        exp_x = exp_q.pop_front();
        checkOutput("xfer", {20'd0, got_x.we, got_x.adr, got_x.dat},
                    {20'd0, exp_x.we, exp_x.adr, exp_x.dat});
      end
      ier_now = got_x.we && got_x.adr == 3'd1 && got_x.dat == 8'h00;
    end
    if (tx_ready) begin
      tx_pulses++;
      checkOutput("tx_ready_at_ack",
                  {31'd0, wb_stb_o && wb_ack_i && wb_we_o && wb_adr_o == 3'd0}, 32'd1);
    end
    cd_prev  = config_done;
    ier_prev = ier_now;
  end

  task automatic pushXfer(input logic we, input logic [2:0] adr, input logic [7:0] dat);
    xfer_t x;
    x.we = we; x.adr = adr; x.dat = dat;
    exp_q.push_back(x);
  endtask

  task automatic pushCfg();
    pushXfer(1'b1, 3'd3, 8'h83);
    pushXfer(1'b1, 3'd0, 8'h82);
    pushXfer(1'b1, 3'd1, 8'h00);
    pushXfer(1'b1, 3'd3, 8'h03);
    pushXfer(1'b1, 3'd2, 8'h07);
    pushXfer(1'b1, 3'd1, 8'h00);
  endtask

  task automatic waitConfig(input string name);
    for (int c = 0; c < 300 && !config_done; c++) @(negedge clk);
    checkOutput({name, "_done"}, {31'd0, config_done}, 32'd1);
    checkOutput({name, "_sb_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    lsr_val  = v.lsr;
    rbr_val  = v.rbr;
    tx_data  = v.txd;
    tx_valid = v.txv;
    if (v.kind == 1) pushXfer(1'b0, 3'd0, v.rbr);
    if (v.kind == 2) pushXfer(1'b1, 3'd0, v.txd);
  endtask

  task automatic consumeRx(input string name);
    lsr_val  = 8'h00;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, "_rx_consumed"}, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   p0, n;
    bit   hit, any_cyc;

    vecs[0] = '{"tx5a",      8'h60, 1'b1, 8'h5A, 8'h00, 2};
    vecs[1] = '{"rxa5",      8'h01, 1'b0, 8'h00, 8'hA5, 1};
    vecs[2] = '{"thr_full",  8'h00, 1'b1, 8'h33, 8'h00, 0};
    vecs[3] = '{"thre_idle", 8'h20, 1'b0, 8'h00, 8'h00, 0};
    vecs[4] = '{"rx3c",      8'h21, 1'b0, 8'h00, 8'h3C, 1};
    vecs[5] = '{"txff",      8'h60, 1'b1, 8'hFF, 8'h00, 2};

    // Reset with start_config already high: release must count as an edge.
    #3 rstn = 1'b0;
    start_config = 1'b1;
    #10;
    checkOutput("rst_ctrl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o, tx_ready, rx_valid, config_done, err}, 32'd0);
    checkOutput("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    checkOutput("rst_adr_dat", {21'd0, wb_adr_o, wb_dat_o}, 32'd0);
    checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
    pushCfg();
    @(negedge clk);
    rstn = 1'b1;
    waitConfig("cfg");

    foreach (vecs[i]) begin
      p0 = tx_pulses;
      applyStimulus(vecs[i]);
      hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
        @(negedge clk);
        if (tx_ready) begin
          tx_valid = 1'b0;
          if (vecs[i].kind == 2) hit = 1'b1;
        end
        if (rx_valid && vecs[i].kind == 1) hit = 1'b1;
      end
      @(negedge clk);
      checkOutput({vecs[i].name, "_txr"}, tx_pulses - p0, (vecs[i].kind == 2) ? 32'd1 : 32'd0);
      checkOutput({vecs[i].name, "_rxv"}, {31'd0, rx_valid}, (vecs[i].kind == 1) ? 32'd1 : 32'd0);
      if (vecs[i].kind == 1) checkOutput({vecs[i].name, "_rxd"}, {24'd0, rx_data}, {24'd0, vecs[i].rbr});
      checkOutput({vecs[i].name, "_sb"}, exp_q.size(), 32'd0);
      exp_q.delete();
      tx_valid = 1'b0;
      lsr_val  = 8'h00;
      if (rx_valid) consumeRx(vecs[i].name);
    end

    // Held byte: another byte waiting in the UART must not be read early.
    rbr_val = 8'hA5;
    lsr_val = 8'h01;
    pushXfer(1'b0, 3'd0, 8'hA5);
    for (int c = 0; c < 60 && !rx_valid; c++) @(negedge clk);
    rbr_val = 8'h77;
    p0 = lsr_reads;
    repeat (30) @(negedge clk);
    checkOutput("hold_rxv", {31'd0, rx_valid}, 32'd1);
    checkOutput("hold_rxd", {24'd0, rx_data}, 32'hA5);
    checkOutput("hold_sb", exp_q.size(), 32'd0);
    checkOutput("hold_repoll", {31'd0, lsr_reads > p0}, 32'd1);
    pushXfer(1'b0, 3'd0, 8'h77);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    for (int c = 0; c < 60 && !rx_valid; c++) @(negedge clk);
    checkOutput("next_rxd", {24'd0, rx_data}, 32'h77);
    checkOutput("next_sb", exp_q.size(), 32'd0);
    exp_q.delete();
    consumeRx("next");

    // Both RX and TX pending: RBR read first, then the THR write.
    p0 = tx_pulses;
    rbr_val  = 8'h11;
    tx_data  = 8'hC3;
    lsr_val  = 8'h61;
    tx_valid = 1'b1;
    pushXfer(1'b0, 3'd0, 8'h11);
    pushXfer(1'b1, 3'd0, 8'hC3);
    hit = 1'b0;
    for (int c = 0; c < 80 && !hit; c++) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_valid = 1'b0;
        hit = 1'b1;
      end
    end
    @(negedge clk);
    checkOutput("prio_txr", tx_pulses - p0, 32'd1);
    checkOutput("prio_rxd", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h11});
    checkOutput("prio_sb", exp_q.size(), 32'd0);
    exp_q.delete();
    consumeRx("prio");

    // Slave stops acking: strobe held for the timeout then dropped with err.
    for (int c = 0; c < 40 && wb_stb_o; c++) @(negedge clk);
    ack_en = 1'b0;
    for (int c = 0; c < 40 && !wb_stb_o; c++) @(negedge clk);
    n = 0;
    while (wb_stb_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_stb_cycles", n, 32'd5);
    checkOutput("timeout_err", {31'd0, err}, 32'd1);
    checkOutput("timeout_cfg_done", {31'd0, config_done}, 32'd0);
    any_cyc = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_cyc |= wb_cyc_o;
    end
    checkOutput("error_bus_idle", {31'd0, any_cyc}, 32'd0);
    ack_en = 1'b1;
    pushCfg();
    start_config = 1'b0;
    @(negedge clk);
    start_config = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("err_cleared", {31'd0, err}, 32'd0);
    waitConfig("recfg");

    // Reset in the middle of a slow THR write.
    slave_delay = 3;
    lsr_val  = 8'h60;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    for (int c = 0; c < 80 && !(wb_stb_o && wb_we_o && wb_adr_o == 3'd0); c++) @(negedge clk);
    p0 = tx_pulses;
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_ctrl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o, tx_ready, rx_valid, config_done, err}, 32'd0);
    checkOutput("midrst_adr_dat_sel", {17'd0, wb_adr_o, wb_dat_o, wb_sel_o}, 32'd0);
    checkOutput("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    tx_valid     = 1'b0;
    start_config = 1'b0;
    slave_delay  = 0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    any_cyc = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_cyc |= wb_cyc_o;
    end
    checkOutput("midrst_no_txr", tx_pulses - p0, 32'd0);
    checkOutput("post_rst_idle", {30'd0, any_cyc, config_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
